// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared widths, entry type and width helpers for the CPU output port (IO_OUTPUT_PORT_TIMESTAMP_EN)
package io_pkg;
    localparam int IO_DATA_W = 16;
    localparam int IO_TS_W   = 16;

    typedef struct packed {
`ifdef IO_OUTPUT_PORT_TIMESTAMP_EN
        logic [IO_TS_W-1:0]   ts;
`endif
        logic [IO_DATA_W-1:0] value;
    } io_entry_t;

    function automatic int io_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Width of one queued entry / m_data: value, plus the capture timestamp when enabled.
    function automatic int io_entry_w(input int data_w);
`ifdef IO_OUTPUT_PORT_TIMESTAMP_EN
        return data_w + IO_TS_W;
`else
        return data_w;
`endif
    endfunction
endpackage

// File: rtl/io_output_port_if.sv
// rtl/io_output_port_if.sv - CPU output-line strobe and consumer stream bundle (IO_OUTPUT_PORT_TIMESTAMP_EN)
interface io_output_port_if
    import io_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W,
    parameter int M_W    = io_entry_w(DATA_W)
);
    logic              cpu_out_wr;
    logic [DATA_W-1:0] cpu_out_data;
    logic              m_valid;
    logic              m_ready;
    logic [M_W-1:0]    m_data;

    modport master (input cpu_out_wr, input cpu_out_data, input m_ready,
                    output m_valid, output m_data);
    modport slave  (output cpu_out_wr, output cpu_out_data, output m_ready,
                    input m_valid, input m_data);
endinterface

// File: rtl/io_out_fifo.sv
// rtl/io_out_fifo.sv - show-ahead FIFO with registered level; a pop frees a slot for a same-cycle push
module io_out_fifo
    import io_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 wdata_i,
    output logic [W-1:0]                 rdata_o,
    output logic [io_level_w(DEPTH)-1:0] level_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = io_level_w(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign level_o = level_q;
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    // Zero when empty so the unreset storage never shows through.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/io_output_port.sv
// rtl/io_output_port.sv - CPU output-line sink: strobe queueing, drop accounting, optional timestamp (IO_OUTPUT_PORT_TIMESTAMP_EN)
module io_output_port
    import io_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = IO_DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    io_output_port_if.master             bus,
    input  logic                         ovf_clr,
    output logic [io_level_w(DEPTH)-1:0] level,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic [CNT_W-1:0]             drop_count
);
    localparam int ENTRY_W = io_entry_w(DATA_W);

    logic               pop, drop;
    logic [ENTRY_W-1:0] wr_entry;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    assign pop  = bus.m_valid & bus.m_ready;
    assign drop = bus.cpu_out_wr & full & ~pop;

`ifdef IO_OUTPUT_PORT_TIMESTAMP_EN
    logic [IO_TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts_q <= '0;
        else      ts_q <= ts_q + 1'b1;
    end

    assign wr_entry = {ts_q, bus.cpu_out_data};
`else
    assign wr_entry = bus.cpu_out_data;
`endif

    io_out_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (bus.cpu_out_wr),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (bus.m_data),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.m_valid = ~empty;

    // A drop in the clear cycle wins: the clear zeroes first, then the drop counts as one.
    always_comb begin
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_d != '1) drop_d = drop_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_q;
endmodule

// File: doc/io_output_port.md
Name: io_output_port

Overview:
- Consumer end of the CPU output line.
- Samples each cycle in which the core asserts its output-line write and queues the 16-bit register value in a small FIFO.
- Drains entries to an external consumer (bench monitor, UART bridge) over a valid/ready handshake.
- Sits beside the core top level; decouples single-cycle `out` instructions from a consumer that may stall.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2
- DATA_W, 16, width of the CPU output value
- CNT_W, 8, width of the saturating drop counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_out_wr  in  1  output-line write strobe from the control generator; one write per cycle while high
- cpu_out_data  in  DATA_W  register value presented on the output line
- m_valid  out  1  head entry available
- m_ready  in  1  consumer accepts head entry this cycle
- m_data  out  DATA_W (DATA_W+16 with timestamp)  head entry
- level  out  $clog2(DEPTH)+1  current occupancy
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- overflow  out  1  sticky: a write was dropped
- drop_count  out  CNT_W  number of dropped writes, saturating
- ovf_clr  in  1  synchronous clear of overflow and drop_count

Behaviour:
- Reset (rst low, asynchronous):
  - pointers and level clear to 0; empty=1, full=0, m_valid=0
  - overflow=0, drop_count=0; m_data=0 (storage array not reset)
- Write: cpu_out_wr=1 at a rising edge with level<DEPTH stores cpu_out_data at wr_ptr; wr_ptr increments, wrapping modulo DEPTH.
- Read: m_valid & m_ready at a rising edge pops the head; rd_ptr increments, wrapping modulo DEPTH.
- m_valid = !empty. m_data = storage[rd_ptr], read combinationally (show-ahead). m_data is stable while m_valid=1 and m_ready=0.
- Latency: a write into an empty FIFO gives m_valid=1 in the cycle after the write edge. There is no same-cycle fall-through.
- Simultaneous write and read:
  - not full: both happen, level unchanged
  - full: the pop frees a slot, so the write is accepted and level stays at DEPTH
  - empty: no pop occurs (m_valid=0); write accepted
- Overflow: a write when full with no pop in the same cycle is dropped and storage is untouched. overflow is set to 1. drop_count increments and saturates at 2^CNT_W-1.
- ovf_clr=1: next edge sets overflow=0 and drop_count=0. If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_count=1.
- level is updated registered, in the same edge as the pointers; full and empty are decoded from level.
- Reset asserted mid-stream discards all queued entries immediately; m_valid falls asynchronously.

Optional Feature:
- Macro: IO_OUTPUT_PORT_TIMESTAMP_EN.
- Defined:
  - a free-running 16-bit cycle counter (reset 0, wraps at 0xFFFF) is captured with each accepted write
  - m_data is {timestamp[15:0], value[DATA_W-1:0]}, width DATA_W+16
  - the timestamp is the counter value in the cycle of the write edge
- Undefined: no counter; m_data width DATA_W.

Decomposition:
- Shared package io_pkg:
  - IO_DATA_W=16, IO_TS_W=16
  - typedef io_entry_t: value plus timestamp when the macro is enabled
  - function for the level width, $clog2(DEPTH)+1
- One sub-module, io_out_fifo: storage array and pointer/level logic with push/pop/full/empty.
- io_output_port adds:
  - strobe sampling
  - overflow and drop accounting
  - timestamp capture
  - handshake outputs

Test Plan:
- Reset, then one write of 0x13B0 with m_ready=0 -> m_valid=1 and m_data=0x13B0 the next cycle; level=1; value held for 5 stalled cycles.
- 8 back-to-back writes 0x0001..0x0008, m_ready=0 -> full=1, level=8. Then m_ready=1 -> 0x0001..0x0008 pop in order over 8 cycles; empty=1 afterwards.
- Full FIFO, 3 further writes with m_ready=0 -> overflow=1, drop_count=3, contents unchanged. ovf_clr pulse -> both cleared.
- Full FIFO with write 0x00AA and pop in the same cycle -> level stays 8, no drop, 0x00AA is the last entry out.
- 300 writes into a full FIFO with CNT_W=8 -> drop_count saturates at 255. rst low mid-drain -> m_valid=0 and level=0 immediately.
- With IO_OUTPUT_PORT_TIMESTAMP_EN: writes at cycles 10 and 14 after reset -> m_data[31:16] equals 10 and 14.
